mc_ctrl: RTL

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: fetch/decode/execute FSM with a memory stall
// watchdog, sticky error state and retired-instruction counter.
module mc_ctrl #(
  parameter int unsigned STALL_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        ir_we,
  output logic        aluout_we,
  output logic        reg_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        iord,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        ext_op,
  output logic [2:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic [2:0]  state,
  output logic        err,
  output logic        instr_done,
  output logic [31:0] retired
);

  localparam int unsigned CNT_W = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_J   = 6'h02;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_LUI = 3'b101;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             err_q, err_d;
  logic [31:0]      retired_q, retired_d;
  logic             funct_ok, op_ok, stall_to;
  logic [2:0]       r_alu_op;

  // R-type funct decode
  always_comb begin
    funct_ok = 1'b1;
    r_alu_op = ALU_ADD;
    case (funct)
      FN_ADDU: r_alu_op = ALU_ADD;
      FN_SUBU: r_alu_op = ALU_SUB;
      FN_AND:  r_alu_op = ALU_AND;
      FN_OR:   r_alu_op = ALU_OR;
      FN_SLT:  r_alu_op = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  // Supported-instruction check used at decode
  always_comb begin
    op_ok = 1'b0;
    case (opcode)
      OP_R:                                       op_ok = funct_ok;
      OP_LW, OP_SW, OP_BEQ, OP_ORI, OP_LUI, OP_J: op_ok = 1'b1;
      default:                                    op_ok = 1'b0;
    endcase
  end

  // Timeout fires on the last allowed wait cycle unless the access completes in it
  assign stall_to = !mem_ready && (wait_q == CNT_W'(STALL_MAX - 1));

  // Next-state, control outputs and counter updates
  always_comb begin
    state_d    = state_q;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    aluout_we  = 1'b0;
    reg_we     = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    ext_op     = 1'b0;
    alu_op     = ALU_ADD;
    pc_src     = 2'd0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      S_IF: begin
        mem_re    = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_ID;
        end else if (stall_to) begin
          state_d = S_ERR;
        end
      end
      S_ID: begin
        alu_src_b = 2'd2;
        ext_op    = 1'b1;
        aluout_we = 1'b1;
        state_d   = op_ok ? S_EX : S_ERR;
      end
      S_EX: begin
        state_d = S_WB;
        case (opcode)
          OP_R: begin
            alu_src_a = 1'b1;
            alu_op    = r_alu_op;
            aluout_we = 1'b1;
            if (!funct_ok) state_d = S_ERR;
          end
          OP_LW, OP_SW: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd3;
            ext_op    = 1'b1;
            aluout_we = 1'b1;
            state_d   = S_MEM;
          end
          OP_ORI: begin
            alu_src_b = 2'd3;
            alu_op    = ALU_OR;
            aluout_we = 1'b1;
          end
          OP_LUI: begin
            alu_src_b = 2'd3;
            alu_op    = ALU_LUI;
            aluout_we = 1'b1;
          end
          OP_BEQ: begin
            alu_src_a  = 1'b1;
            alu_op     = ALU_SUB;
            pc_src     = 2'd1;
            pc_we      = zero;
            instr_done = 1'b1;
            state_d    = S_IF;
          end
          OP_J: begin
            pc_src     = 2'd2;
            pc_we      = 1'b1;
            instr_done = 1'b1;
            state_d    = S_IF;
          end
          default: state_d = S_ERR;
        endcase
      end
      S_MEM: begin
        iord = 1'b1;
        if (opcode == OP_LW) begin
          mem_re = 1'b1;
          if (mem_ready)     state_d = S_WB;
          else if (stall_to) state_d = S_ERR;
        end else if (opcode == OP_SW) begin
          mem_we = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = S_IF;
          end else if (stall_to) begin
            state_d = S_ERR;
          end
        end else begin
          state_d = S_ERR;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_dst    = (opcode == OP_R);
        mem_to_reg = (opcode == OP_LW);
        instr_done = 1'b1;
        state_d    = S_IF;
      end
      default: state_d = S_ERR;
    endcase

    // Reset held low aborts any in-flight access immediately
    if (!reset) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      aluout_we  = 1'b0;
      reg_we     = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      instr_done = 1'b0;
    end

    if ((state_q == S_IF || state_q == S_MEM) && !mem_ready && (state_d == state_q))
      wait_d = wait_q + CNT_W'(1);
    else
      wait_d = '0;

    err_d     = (state_d == S_ERR);
    retired_d = instr_done ? retired_q + 32'd1 : retired_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IF;
      wait_q    <= '0;
      err_q     <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  assign state   = 3'(state_q);
  assign err     = err_q;
  assign retired = retired_q;

endmodule
